// File: rtl/sram_access_ctrl.sv
// Access sequencer for a small SRAM macro: precharge, wordline, optional sense, response.
// Every array-facing signal comes straight from a flop so the analog side never sees decode glitches.
module sram_access_ctrl #(
  parameter int PRE_CYC = 1,
  parameter int WL_CYC  = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       req_valid,
  output logic       req_ready,
  input  logic       req_we,
  input  logic [2:0] req_addr,
  input  logic [7:0] req_wdata,
  output logic       rsp_valid,
  output logic [7:0] rsp_rdata,
  output logic [2:0] dec_a,
  output logic       dec_en,
  output logic       pre_en,
  output logic       wr_en,
  output logic [7:0] din,
  output logic       sae,
  input  logic [7:0] sa_out
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_PRE,
    S_ACCESS,
    S_SENSE,
    S_RESP
  } state_e;

  localparam logic [3:0] PRE_LD = 4'(PRE_CYC - 1);
  localparam logic [3:0] WL_LD  = 4'(WL_CYC - 1);

  state_e     state_q, state_d;
  logic [3:0] cnt_q, cnt_d;
  logic [2:0] addr_q, addr_d;
  logic       we_q, we_d;
  logic [7:0] wdata_q, wdata_d;

  logic       req_ready_q, req_ready_d;
  logic       rsp_valid_q, rsp_valid_d;
  logic [7:0] rsp_rdata_q, rsp_rdata_d;
  logic [2:0] dec_a_q, dec_a_d;
  logic       dec_en_q, dec_en_d;
  logic       pre_en_q, pre_en_d;
  logic       wr_en_q, wr_en_d;
  logic [7:0] din_q, din_d;
  logic       sae_q, sae_d;

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    addr_d      = addr_q;
    we_d        = we_q;
    wdata_d     = wdata_q;
    rsp_rdata_d = rsp_rdata_q;

    // Phase counter is loaded with length-1 and the phase ends on terminal count zero.
    case (state_q)
      S_IDLE: begin
        if (req_valid) begin
          addr_d  = req_addr;
          we_d    = req_we;
          wdata_d = req_wdata;
          cnt_d   = PRE_LD;
          state_d = S_PRE;
        end
      end
      S_PRE: begin
        if (cnt_q == 4'd0) begin
          cnt_d   = WL_LD;
          state_d = S_ACCESS;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      S_ACCESS: begin
        if (cnt_q == 4'd0) begin
          state_d = we_q ? S_RESP : S_SENSE;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      S_SENSE: begin
        rsp_rdata_d = sa_out;
        state_d     = S_RESP;
      end
      S_RESP: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    // Outputs are decoded from the next state so they register in step with it.
    req_ready_d = (state_d == S_IDLE);
    pre_en_d    = (state_d == S_PRE);
    dec_en_d    = (state_d == S_ACCESS) || (state_d == S_SENSE);
    dec_a_d     = dec_en_d ? addr_d : 3'd0;
    wr_en_d     = (state_d == S_ACCESS) && we_d;
    din_d       = wr_en_d ? wdata_d : 8'd0;
    sae_d       = (state_d == S_SENSE);
    rsp_valid_d = (state_d == S_RESP);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      cnt_q       <= 4'd0;
      addr_q      <= 3'd0;
      we_q        <= 1'b0;
      wdata_q     <= 8'd0;
      req_ready_q <= 1'b1;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= 8'd0;
      dec_a_q     <= 3'd0;
      dec_en_q    <= 1'b0;
      pre_en_q    <= 1'b0;
      wr_en_q     <= 1'b0;
      din_q       <= 8'd0;
      sae_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      addr_q      <= addr_d;
      we_q        <= we_d;
      wdata_q     <= wdata_d;
      req_ready_q <= req_ready_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
      dec_a_q     <= dec_a_d;
      dec_en_q    <= dec_en_d;
      pre_en_q    <= pre_en_d;
      wr_en_q     <= wr_en_d;
      din_q       <= din_d;
      sae_q       <= sae_d;
    end
  end

  assign req_ready = req_ready_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rsp_rdata_q;
  assign dec_a     = dec_a_q;
  assign dec_en    = dec_en_q;
  assign pre_en    = pre_en_q;
  assign wr_en     = wr_en_q;
  assign din       = din_q;
  assign sae       = sae_q;

endmodule

// File: tb/tb_sram_access_ctrl.sv
// Scoreboard bench: directed accesses on a default-timing controller, then a random sweep
// on a PRE_CYC=3 / WL_CYC=1 controller, each backed by a small array model.
module tb_sram_access_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst;

  logic       req_valid, req_ready, req_we, rsp_valid, dec_en, pre_en, wr_en, sae;
  logic [2:0] req_addr, dec_a;
  logic [7:0] req_wdata, rsp_rdata, din, sa_out;

  logic       req_valid2, req_ready2, req_we2, rsp_valid2, dec_en2, pre_en2, wr_en2, sae2;
  logic [2:0] req_addr2, dec_a2;
  logic [7:0] req_wdata2, rsp_rdata2, din2, sa_out2;

  sram_access_ctrl u_dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata),
    .dec_a(dec_a), .dec_en(dec_en), .pre_en(pre_en), .wr_en(wr_en),
    .din(din), .sae(sae), .sa_out(sa_out)
  );

  sram_access_ctrl #(.PRE_CYC(3), .WL_CYC(1)) u_dut2 (
    .clk(clk), .rst(rst),
    .req_valid(req_valid2), .req_ready(req_ready2), .req_we(req_we2),
    .req_addr(req_addr2), .req_wdata(req_wdata2),
    .rsp_valid(rsp_valid2), .rsp_rdata(rsp_rdata2),
    .dec_a(dec_a2), .dec_en(dec_en2), .pre_en(pre_en2), .wr_en(wr_en2),
    .din(din2), .sae(sae2), .sa_out(sa_out2)
  );

  // Array models: written by the write drivers, read out through the sense amps.
  logic [7:0] mem1 [8];
  logic [7:0] mem2 [8];
  assign sa_out  = sae  ? mem1[dec_a]  : 8'h00;
  assign sa_out2 = sae2 ? mem2[dec_a2] : 8'h00;
  always @(posedge clk) if (wr_en)  mem1[dec_a]  <= din;
  always @(posedge clk) if (wr_en2) mem2[dec_a2] <= din2;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [7:0] rdata;
    int         acc;
    int         lat;
  } exp_t;

  exp_t q1[$];
  exp_t q2[$];

  int n_checks = 0;
  int n_fail   = 0;
  int rsp2_cnt = 0;

  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual=%0h required=%0h (t=%0t)", name, act, exp, $time);
    end
  endfunction

  always @(negedge clk) begin
    exp_t e;
    if (!rst) begin
      chk("excl_pre_dec", 32'(pre_en & dec_en), 0);
      chk("excl_wr_sae", 32'(wr_en & sae), 0);
      if (!dec_en) chk("dec_a_zero", 32'(dec_a), 0);
      if (!wr_en) chk("din_zero", 32'(din), 0);
      if (rsp_valid) begin
        if (q1.size() == 0) begin
          chk("rsp_unexpected", 32'(rsp_valid), 0);
        end else begin
          e = q1.pop_front();
          chk("rsp_rdata", 32'(rsp_rdata), 32'(e.rdata));
          chk("rsp_latency", 32'(cyc - e.acc), 32'(e.lat));
        end
      end
    end
  end

  always @(negedge clk) begin
    exp_t e;
    if (!rst) begin
      chk("sw_excl_pre_dec", 32'(pre_en2 & dec_en2), 0);
      chk("sw_excl_wr_sae", 32'(wr_en2 & sae2), 0);
      if (!dec_en2) chk("sw_dec_a_zero", 32'(dec_a2), 0);
      if (!wr_en2) chk("sw_din_zero", 32'(din2), 0);
      if (rsp_valid2) begin
        rsp2_cnt++;
        if (q2.size() == 0) begin
          chk("sw_rsp_unexpected", 32'(rsp_valid2), 0);
        end else begin
          e = q2.pop_front();
          chk("sw_rsp_rdata", 32'(rsp_rdata2), 32'(e.rdata));
          chk("sw_rsp_latency", 32'(cyc - e.acc), 32'(e.lat));
        end
      end
    end
  end

  // Called at a falling edge; returns just after the accepting rising edge with req_valid still high.
  task automatic issue1(input logic we, input logic [2:0] a, input logic [7:0] d,
                        input logic [7:0] exp_rd, output int acc);
    exp_t e;
    bit   done;
    done = 0;
    acc  = -1;
    req_valid = 1'b1; req_we = we; req_addr = a; req_wdata = d;
    for (int i = 0; i < 40 && !done; i++) begin
      if (req_ready) begin
        e.rdata = exp_rd; e.acc = cyc; e.lat = we ? 4 : 5;
        q1.push_back(e);
        acc  = cyc;
        done = 1;
        @(posedge clk);
      end else begin
        @(negedge clk);
      end
    end
    if (!done) chk("issue1_timeout", 32'(done), 1);
  endtask

  task automatic issue2(input logic we, input logic [2:0] a, input logic [7:0] d,
                        input logic [7:0] exp_rd);
    exp_t e;
    bit   done;
    done = 0;
    req_valid2 = 1'b1; req_we2 = we; req_addr2 = a; req_wdata2 = d;
    for (int i = 0; i < 40 && !done; i++) begin
      if (req_ready2) begin
        e.rdata = exp_rd; e.acc = cyc; e.lat = we ? 5 : 6;
        q2.push_back(e);
        done = 1;
        @(posedge clk);
      end else begin
        @(negedge clk);
      end
    end
    if (!done) chk("issue2_timeout", 32'(done), 1);
  endtask

  task automatic chk_idle_outputs(input string tag);
    chk({tag, "_req_ready"}, 32'(req_ready), 1);
    chk({tag, "_rsp_valid"}, 32'(rsp_valid), 0);
    chk({tag, "_dec_en"}, 32'(dec_en), 0);
    chk({tag, "_pre_en"}, 32'(pre_en), 0);
    chk({tag, "_wr_en"}, 32'(wr_en), 0);
    chk({tag, "_sae"}, 32'(sae), 0);
    chk({tag, "_dec_a"}, 32'(dec_a), 0);
    chk({tag, "_din"}, 32'(din), 0);
  endtask

  logic [7:0] ref2 [8];
  logic [7:0] last2;

  initial begin
    int acc_a, acc_b, acc_x;
    logic       we;
    logic [2:0] a;
    logic [7:0] d, exp_rd;

    for (int i = 0; i < 8; i++) begin
      mem1[i] = 8'(i * 8'h11);
      mem2[i] = 8'(i * 8'h11);
      ref2[i] = 8'(i * 8'h11);
    end
    last2 = 8'h00;
    rst = 1'b1;
    req_valid = 1'b0; req_we = 1'b0; req_addr = 3'd0; req_wdata = 8'd0;
    req_valid2 = 1'b0; req_we2 = 1'b0; req_addr2 = 3'd0; req_wdata2 = 8'd0;
    repeat (3) @(negedge clk);
    chk_idle_outputs("reset");
    chk("reset_rsp_rdata", 32'(rsp_rdata), 0);
    rst = 1'b0;
    @(negedge clk);
    chk_idle_outputs("post_reset");

    // Write 0xA5 to row 7.
    issue1(1'b1, 3'd7, 8'hA5, 8'h00, acc_a);
    #1 req_valid = 1'b0;
    @(negedge clk);
    chk("wr_c1_pre_en", 32'(pre_en), 1);
    chk("wr_c1_dec_en", 32'(dec_en), 0);
    chk("wr_c1_req_ready", 32'(req_ready), 0);
    for (int c = 2; c <= 3; c++) begin
      @(negedge clk);
      chk("wr_acc_dec_en", 32'(dec_en), 1);
      chk("wr_acc_dec_a", 32'(dec_a), 7);
      chk("wr_acc_wr_en", 32'(wr_en), 1);
      chk("wr_acc_din", 32'(din), 32'h A5);
      chk("wr_acc_pre_en", 32'(pre_en), 0);
    end
    @(negedge clk);
    chk("wr_c4_rsp_valid", 32'(rsp_valid), 1);
    chk("wr_c4_wr_en", 32'(wr_en), 0);
    chk("wr_c4_req_ready", 32'(req_ready), 0);
    @(negedge clk);
    chk("wr_c5_req_ready", 32'(req_ready), 1);
    chk("wr_c5_rsp_valid", 32'(rsp_valid), 0);

    // Read row 7 while a second request for row 2 is held pending.
    issue1(1'b0, 3'd7, 8'h00, 8'hA5, acc_a);
    #1 req_addr = 3'd2; req_wdata = 8'h77;
    for (int c = 1; c <= 3; c++) begin
      @(negedge clk);
      chk("rd_sae_low", 32'(sae), 0);
      chk("rd_busy_ready", 32'(req_ready), 0);
      if (c >= 2) chk("rd_dec_a_held7", 32'(dec_a), 7);
    end
    @(negedge clk);
    chk("rd_c4_sae", 32'(sae), 1);
    chk("rd_c4_dec_en", 32'(dec_en), 1);
    chk("rd_c4_dec_a", 32'(dec_a), 7);
    chk("rd_c4_rsp_valid", 32'(rsp_valid), 0);
    @(negedge clk);
    chk("rd_c5_sae", 32'(sae), 0);
    chk("rd_c5_rsp_valid", 32'(rsp_valid), 1);
    chk("rd_c5_req_ready", 32'(req_ready), 0);
    issue1(1'b0, 3'd2, 8'h77, 8'h22, acc_b);
    chk("b2b_accept_gap", 32'(acc_b - acc_a), 6);
    #1 req_valid = 1'b0;
    repeat (2) @(negedge clk);
    chk("rd2_dec_a", 32'(dec_a), 2);
    chk("rd2_dec_en", 32'(dec_en), 1);
    chk("rd2_wr_en", 32'(wr_en), 0);

    // Write then read back row 0; rsp_rdata must hold 0x22 across the write.
    @(negedge clk);
    issue1(1'b1, 3'd0, 8'h3C, 8'h22, acc_x);
    #1 req_valid = 1'b0;
    @(negedge clk);
    issue1(1'b0, 3'd0, 8'h00, 8'h3C, acc_x);
    #1 req_valid = 1'b0;
    @(negedge clk);
    issue1(1'b0, 3'd5, 8'h00, 8'h55, acc_x);
    #1 req_valid = 1'b0;
    @(negedge clk);

    // Reset during ACCESS of a write to row 3.
    issue1(1'b1, 3'd3, 8'h5A, 8'h55, acc_x);
    #1 req_valid = 1'b0;
    repeat (2) @(negedge clk);
    chk("mid_c2_dec_en", 32'(dec_en), 1);
    chk("mid_c2_wr_en", 32'(wr_en), 1);
    rst = 1'b1;
    q1.delete();
    @(negedge clk);
    chk("mid_rst_dec_en", 32'(dec_en), 0);
    chk("mid_rst_wr_en", 32'(wr_en), 0);
    chk("mid_rst_req_ready", 32'(req_ready), 1);
    chk("mid_rst_rsp_valid", 32'(rsp_valid), 0);
    chk("mid_rst_rsp_rdata", 32'(rsp_rdata), 0);
    rst = 1'b0;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      chk("mid_rst_no_rsp", 32'(rsp_valid), 0);
    end
    chk("directed_queue_empty", 32'(q1.size()), 0);

    // Random sweep on the PRE_CYC=3 / WL_CYC=1 instance.
    for (int n = 0; n < 200; n++) begin
      we = 1'($urandom_range(0, 1));
      a  = 3'($urandom_range(0, 7));
      d  = 8'($urandom_range(0, 255));
      if (we) begin
        exp_rd  = last2;
        ref2[a] = d;
      end else begin
        exp_rd = ref2[a];
        last2  = ref2[a];
      end
      issue2(we, a, d, exp_rd);
      #1 req_valid2 = 1'b0;
      @(negedge clk);
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end
    for (int i = 0; i < 50 && q2.size() != 0; i++) @(negedge clk);
    chk("sweep_queue_empty", 32'(q2.size()), 0);
    chk("sweep_rsp_count", 32'(rsp2_cnt), 200);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
